pcf8574_lcd_target: RTL and testbench
=====================================

# pcf8574_lcd_target

I2C target model of the PCF8574 LCD backpack. It is the responder on the `scl`/`sda` bus driven by `lcd_write_cmd_data`.
- Acknowledges its address.
- Latches written bytes as the expander port and returns the port on reads.
- Reassembles the HD44780 4-bit nibble stream into command/data bytes.

It serves as the bus-functional endpoint in the LCD subsystem bench and as an on-chip loopback monitor.

## Interface
- `I2C_ADDR`, default 7'h27: 7-bit target address.
- `clk`  in  1  system clock. Must be ≥ 8× the SCL rate (the 1 MHz LCD clock qualifies).
- `rst_n`  in  1  asynchronous, active-low reset.
- `scl`  in  1  I2C clock. Input only; the target never stretches SCL.
- `sda`  inout  1  I2C data, open-drain: driven 1'b0 or 1'bz, never 1.
- `port_out`  out  8  expander latch. P0=RS, P1=RW, P2=EN, P3=BL, P7:4=D7:D4.
- `port_wr`  out  1  one-cycle pulse when `port_out` is updated.
- `lcd_byte`  out  8  reassembled HD44780 byte.
- `lcd_rs`  out  1  RS captured with the low nibble.
- `lcd_valid`  out  1  one-cycle pulse when `lcd_byte`/`lcd_rs` are updated.
- `nib_clr`  in  1  synchronous clear of the nibble phase, used for the 8-bit-mode init nibbles.
- `busy`  out  1  high from START until STOP.

## Operation
- `scl` and `sda` pass through 2-flop synchronizers, then edge detection on the synchronized copies.
- Bus conditions:
  - START: `sda` falls while `scl` is high.
  - STOP: `sda` rises while `scl` is high.
- Data is sampled on `scl` rising edges. `sda` is changed only on the clk after an `scl` falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
  - IDLE → ADDR on START. A START in any state (repeated start) → ADDR with the bit counter cleared.
  - ADDR: shift 8 bits MSB first.
    - Address match → ADDR_ACK.
    - Mismatch → IGNORE (no ACK).
  - ADDR_ACK: drive `sda` low from the `scl` fall after bit 8 until the next `scl` fall.
    - R/W=0 → WR_DATA.
    - R/W=1 → RD_DATA, with `port_out` loaded into the shift register.
  - WR_DATA: after 8 bits, `port_out` ← byte and pulse `port_wr` → WR_ACK. WR_ACK drives ACK as in ADDR_ACK → WR_DATA. Unlimited bytes per transaction.
  - RD_DATA: drive the MSB-first bits; a 1 releases `sda` to z. After bit 8, release `sda` → RD_ACK.
  - RD_ACK: sample the controller's ACK on `scl` rise.
    - 0 → reload `port_out` → RD_DATA.
    - 1 (NACK) → IGNORE.
  - IGNORE: `sda` released; wait for STOP/START.
  - STOP in any state → IDLE, `sda` released, `busy`=0.
- Nibble decoder runs on every `port_wr` where the old P2=1 and the new P2=0 (EN falling edge):
  - If new P1=1 (LCD read), ignore; the phase is unchanged.
  - Phase 0: hold P7:4 as the high nibble; phase ← 1.
  - Phase 1: `lcd_byte` ← {held, P7:4}, `lcd_rs` ← P0, pulse `lcd_valid`; phase ← 0.
- `nib_clr`=1 forces phase 0. If `nib_clr` and an EN fall coincide, `nib_clr` wins and the nibble is discarded.
- STOP and repeated START leave the phase and the EN history unchanged.

## Timing
- Reset values:
  - `port_out`=8'hFF (PCF8574 power-up).
  - `port_wr`=0, `lcd_byte`=8'h00, `lcd_rs`=0, `lcd_valid`=0, `busy`=0.
  - `sda`=z, nibble phase=0, FSM=IDLE.
- Reset is asynchronous: asserting `rst_n` releases `sda` immediately, including mid-ACK or mid-read.
- Pin-to-internal latency is 2 clk (synchronizer) plus 1 clk (edge register).
- `port_wr` and the new `port_out` appear 3 clk after the `scl` rise that samples data bit 0.
- `lcd_valid` is asserted 1 clk after the qualifying `port_wr`.
- ACK/data drive changes 3 clk after the `scl` fall. The setup margin at ≥ 8× oversampling is within the standard-mode spec.
- `busy` rises 3 clk after START and falls 3 clk after STOP.
- Glitches shorter than 1 clk on `scl`/`sda` are not filtered. Bus-free timing is the controller's responsibility.

## Test plan
- Write 0x4E (0x27, W), 0x0C, STOP → ACK on address and data; `port_out`=0x0C, one `port_wr` pulse, `busy` returns to 0.
- Write address 0x7E (0x3F) → `sda` stays z at the 9th clock; `port_out` stays 0xFF; no `port_wr`.
- Write 0x4E, 0x4D, 0x49, 0x1D, 0x19 → exactly one `lcd_valid` with `lcd_byte`=0x41, `lcd_rs`=1.
- Same stream with `nib_clr` pulsed after 0x49 → no `lcd_valid`; the next pair yields a byte with high nibble 0x1.
- After `port_out`=0xA5, send 0x4F, read one byte with NACK, STOP → `sda` bits 1,0,1,0,0,1,0,1; FSM in IGNORE until STOP; `port_out` unchanged.
- Assert `rst_n`=0 during WR_ACK with `sda` driven low → `sda`=z the same cycle; `port_out`=0xFF; next START/0x4E is ACKed.

Source files
------------

// File: rtl/pcf8574_lcd_target.sv
// I2C target model of a PCF8574 LCD backpack: acknowledges its address, latches/returns the
// expander port, and rebuilds HD44780 bytes from the 4-bit EN-strobed nibble stream.
module pcf8574_lcd_target #(
  parameter logic [6:0] I2C_ADDR = 7'h27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] port_out,
  output logic       port_wr,
  output logic [7:0] lcd_byte,
  output logic       lcd_rs,
  output logic       lcd_valid,
  input  logic       nib_clr,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  scl_q, sda_q;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [7:0]  port_out_nxt;
  logic        port_wr_nxt;
  logic        sda_low, sda_low_nxt;
  logic        busy_nxt;
  logic        scl_rise, scl_fall, start_det, stop_det, sda_in;
  logic        en_prev, phase, en_fall;
  logic [3:0]  hold;

  // Open-drain pad: only ever pulls low.
  assign sda = sda_low ? 1'b0 : 1'bz;

  // Two-flop synchronizers followed by one edge-history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign sda_in    = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

  // Bus FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 8'h00;
      sda_low  <= 1'b0;
      busy     <= 1'b0;
      port_out <= 8'hFF;
      port_wr  <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      sda_low  <= sda_low_nxt;
      busy     <= busy_nxt;
      port_out <= port_out_nxt;
      port_wr  <= port_wr_nxt;
    end
  end

  // Next-state logic; in the ACK states bit_cnt marks whether the ACK slot has begun.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    sda_low_nxt  = sda_low;
    busy_nxt     = busy;
    port_out_nxt = port_out;
    port_wr_nxt  = 1'b0;
    if (stop_det) begin
      state_nxt   = IDLE;
      sda_low_nxt = 1'b0;
      busy_nxt    = 1'b0;
    end else if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = 4'd0;
      sda_low_nxt = 1'b0;
      busy_nxt    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          sda_low_nxt = 1'b0;
        end
        ADDR: begin
          if (scl_rise) begin
            shreg_nxt = {shreg[6:0], sda_in};
            if (bit_cnt == 4'd7) begin
              bit_cnt_nxt = 4'd0;
              state_nxt   = (shreg[6:0] == I2C_ADDR) ? ADDR_ACK : IGNORE;
            end else begin
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt;
          end
        end
        ADDR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_low_nxt = 1'b1;
              bit_cnt_nxt = 4'd1;
            end else begin
              sda_low_nxt = 1'b0;
              bit_cnt_nxt = 4'd0;
              if (state == ADDR_ACK && shreg[0]) begin
                state_nxt   = RD_DATA;
                shreg_nxt   = {port_out[6:0], 1'b0};
                sda_low_nxt = ~port_out[7];
              end else begin
                state_nxt = WR_DATA;
              end
            end
          end else begin
            bit_cnt_nxt = bit_cnt;
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shreg_nxt = {shreg[6:0], sda_in};
            if (bit_cnt == 4'd7) begin
              port_out_nxt = {shreg[6:0], sda_in};
              port_wr_nxt  = 1'b1;
              bit_cnt_nxt  = 4'd0;
              state_nxt    = WR_ACK;
            end else begin
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_low_nxt = 1'b0;
              bit_cnt_nxt = 4'd0;
              state_nxt   = RD_ACK;
            end else begin
              sda_low_nxt = ~shreg[7];
              shreg_nxt   = {shreg[6:0], 1'b0};
            end
          end else begin
            bit_cnt_nxt = bit_cnt;
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_in) begin
              state_nxt = IGNORE;
            end else begin
              bit_cnt_nxt = 4'd1;
            end
          end else if (scl_fall && bit_cnt == 4'd1) begin
            state_nxt   = RD_DATA;
            bit_cnt_nxt = 4'd0;
            shreg_nxt   = {port_out[6:0], 1'b0};
            sda_low_nxt = ~port_out[7];
          end else begin
            bit_cnt_nxt = bit_cnt;
          end
        end
        IGNORE: begin
          sda_low_nxt = 1'b0;
        end
        default: begin
          state_nxt   = IDLE;
          sda_low_nxt = 1'b0;
        end
      endcase
    end
  end

  assign en_fall = port_wr & en_prev & ~port_out[2];

  // HD44780 nibble reassembly on EN falling edges of the expander port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_prev   <= 1'b1;
      phase     <= 1'b0;
      hold      <= 4'h0;
      lcd_byte  <= 8'h00;
      lcd_rs    <= 1'b0;
      lcd_valid <= 1'b0;
    end else begin
      lcd_valid <= 1'b0;
      if (port_wr) begin
        en_prev <= port_out[2];
      end
      if (nib_clr) begin
        phase <= 1'b0;
      end else if (en_fall && !port_out[1]) begin
        if (!phase) begin
          hold  <= port_out[7:4];
          phase <= 1'b1;
        end else begin
          lcd_byte  <= {hold, port_out[7:4]};
          lcd_rs    <= port_out[0];
          lcd_valid <= 1'b1;
          phase     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcf8574_lcd_target.sv
// Scoreboard bench for pcf8574_lcd_target: a bit-banged I2C controller drives the bus while
// a byte-level reference model predicts port writes and reassembled LCD bytes.
module tb_pcf8574_lcd_target;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       ctrl_low = 1'b0;
  logic       nib_clr = 1'b0;
  wire        sda;
  logic [7:0] port_out;
  logic       port_wr;
  logic [7:0] lcd_byte;
  logic       lcd_rs;
  logic       lcd_valid;
  logic       busy;

  assign sda = ctrl_low ? 1'b0 : 1'bz;
  pullup (sda);

  pcf8574_lcd_target #(.I2C_ADDR(7'h27)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .port_out(port_out), .port_wr(port_wr),
    .lcd_byte(lcd_byte), .lcd_rs(lcd_rs), .lcd_valid(lcd_valid),
    .nib_clr(nib_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  int         total_cnt = 0;
  int         pass_cnt  = 0;
  int         lcd_cnt   = 0;
  logic [7:0] exp_port_q[$];
  logic [8:0] exp_lcd_q[$];
  logic [7:0] m_port  = 8'hFF;
  logic       m_en    = 1'b1;
  logic       m_phase = 1'b0;
  logic [3:0] m_hold  = 4'h0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  // Reference model: one byte latched into the expander port.
  task automatic model_write(input logic [7:0] b);
    exp_port_q.push_back(b);
    if (m_en && !b[2] && !b[1]) begin
      if (!m_phase) begin
        m_hold  = b[7:4];
        m_phase = 1'b1;
      end else begin
        exp_lcd_q.push_back({b[0], m_hold, b[7:4]});
        m_phase = 1'b0;
      end
    end
    m_en   = b[2];
    m_port = b;
  endtask

  task automatic model_reset();
    m_port  = 8'hFF;
    m_en    = 1'b1;
    m_phase = 1'b0;
    m_hold  = 4'h0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a pulse.
  initial begin
    logic prev_wr;
    logic [8:0] e9;
    logic [7:0] e8;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (port_wr) begin
          if (exp_port_q.size() == 0) begin
            total_cnt++;
            $display("FAIL port_wr_extra: got port_out=%0h expected no pulse", port_out);
          end else begin
            e8 = exp_port_q.pop_front();
            check("port_wr_data", 32'(port_out), 32'(e8));
          end
        end
        if (lcd_valid) begin
          lcd_cnt++;
          check("lcd_valid_latency", 32'(prev_wr), 32'd1);
          if (exp_lcd_q.size() == 0) begin
            total_cnt++;
            $display("FAIL lcd_valid_extra: got rs/byte=%0h expected no pulse", {lcd_rs, lcd_byte});
          end else begin
            e9 = exp_lcd_q.pop_front();
            check("lcd_rs_byte", 32'({lcd_rs, lcd_byte}), 32'(e9));
          end
        end
      end
      prev_wr = port_wr;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    ctrl_low = 1'b0; tick(4);
    scl = 1'b1;      tick(8);
    ctrl_low = 1'b1; tick(8);
    scl = 1'b0;      tick(4);
  endtask

  task automatic i2c_stop();
    ctrl_low = 1'b1; tick(4);
    scl = 1'b1;      tick(8);
    ctrl_low = 1'b0; tick(8);
  endtask

  task automatic send_bit(input logic b, output logic s);
    ctrl_low = ~b; tick(4);
    scl = 1'b1;    tick(6);
    s = sda;       tick(2);
    scl = 1'b0;    tick(4);
  endtask

  // Eight data bits; optionally checks port_wr lands exactly 3 clk after the last scl rise.
  task automatic send_bits8(input logic [7:0] b, input logic chk_lat);
    for (int i = 7; i >= 0; i--) begin
      ctrl_low = ~b[i]; tick(4);
      scl = 1'b1;
      if (chk_lat && i == 0) begin
        tick(2);
        check("port_wr_early", 32'(port_wr), 32'd0);
        tick(1);
        check("port_wr_at_3clk", 32'(port_wr), 32'd1);
        check("port_out_at_3clk", 32'(port_out), 32'(b));
        tick(3);
      end else begin
        tick(6);
      end
      tick(2);
      scl = 1'b0; tick(4);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, input logic chk_lat, output logic ack);
    logic s;
    send_bits8(b, chk_lat);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(nack, s);
  endtask

  task automatic wr_lcd(input logic [7:0] b);
    logic ack;
    model_write(b);
    write_byte(b, 1'b0, ack);
    check("data_ack", 32'(ack), 32'd1);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [6:0] addr;
    int         n0;
    int         kind;
    int         nb;

    tick(3);
    check("rst_port_out", 32'(port_out), 32'hFF);
    check("rst_port_wr", 32'(port_wr), 32'd0);
    check("rst_lcd", 32'({lcd_valid, lcd_rs, lcd_byte}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sda", 32'(sda), 32'd1);
    rst_n = 1'b1;
    tick(4);

    // Wrong address: no ACK, port untouched, subsequent bytes ignored.
    i2c_start();
    write_byte(8'h7E, 1'b0, ack);
    check("bad_addr_nack", 32'(ack), 32'd0);
    write_byte(8'h12, 1'b0, ack);
    check("ignore_nack", 32'(ack), 32'd0);
    i2c_stop();
    tick(4);
    check("bad_addr_port", 32'(port_out), 32'hFF);

    // Simple write with exact latency check.
    i2c_start();
    tick(1);
    check("busy_in_xfer", 32'(busy), 32'd1);
    write_byte(8'h4E, 1'b0, ack);
    check("addr_ack", 32'(ack), 32'd1);
    model_write(8'h0C);
    write_byte(8'h0C, 1'b1, ack);
    check("data_ack_0c", 32'(ack), 32'd1);
    i2c_stop();
    tick(4);
    check("busy_after_stop", 32'(busy), 32'd0);
    check("port_0c", 32'(port_out), 32'h0C);

    // Nibble pair 0x4_/0x1_ with RS=1 gives 0x41.
    n0 = lcd_cnt;
    i2c_start();
    write_byte(8'h4E, 1'b0, ack);
    check("addr_ack_lcd", 32'(ack), 32'd1);
    wr_lcd(8'h4D); wr_lcd(8'h49); wr_lcd(8'h1D); wr_lcd(8'h19);
    i2c_stop();
    tick(2);
    check("lcd_one_pulse", 32'(lcd_cnt - n0), 32'd1);
    check("lcd_0x41", 32'({lcd_rs, lcd_byte}), 32'h141);

    // nib_clr after the first nibble discards it.
    n0 = lcd_cnt;
    i2c_start();
    write_byte(8'h4E, 1'b0, ack);
    wr_lcd(8'h4D); wr_lcd(8'h49);
    nib_clr = 1'b1; tick(1); nib_clr = 1'b0;
    m_phase = 1'b0;
    wr_lcd(8'h1D); wr_lcd(8'h19);
    tick(2);
    check("nib_clr_no_pulse", 32'(lcd_cnt - n0), 32'd0);
    wr_lcd(8'h2D); wr_lcd(8'h29);
    i2c_stop();
    tick(2);
    check("nib_clr_pulse", 32'(lcd_cnt - n0), 32'd1);
    check("nib_clr_byte", 32'({lcd_rs, lcd_byte}), 32'h112);

    // Read back 0xA5 with NACK, then the target must stay off the bus until STOP.
    i2c_start();
    write_byte(8'h4E, 1'b0, ack);
    wr_lcd(8'hA5);
    i2c_stop();
    i2c_start();
    write_byte(8'h4F, 1'b0, ack);
    check("rd_addr_ack", 32'(ack), 32'd1);
    read_byte(1'b1, d);
    check("rd_a5", 32'(d), 32'hA5);
    read_byte(1'b1, d);
    check("rd_ignore_released", 32'(d), 32'hFF);
    check("rd_ignore_busy", 32'(busy), 32'd1);
    i2c_stop();
    tick(4);
    check("rd_port_kept", 32'(port_out), 32'hA5);
    check("rd_busy_low", 32'(busy), 32'd0);

    // Asynchronous reset while the target is pulling sda low for an ACK.
    i2c_start();
    write_byte(8'h4E, 1'b0, ack);
    model_write(8'h55);
    send_bits8(8'h55, 1'b0);
    ctrl_low = 1'b0;
    check("ack_driving", 32'(sda), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_releases_sda", 32'(sda), 32'd1);
    check("rst_port_ff", 32'(port_out), 32'hFF);
    model_reset();
    tick(3);
    rst_n = 1'b1;
    tick(4);
    i2c_start();
    write_byte(8'h4E, 1'b0, ack);
    check("post_rst_ack", 32'(ack), 32'd1);
    i2c_stop();
    tick(4);

    // Randomized transactions.
    for (int t = 0; t < 14; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        nib_clr = 1'b1; tick(1); nib_clr = 1'b0;
        m_phase = 1'b0;
      end
      kind = $urandom_range(0, 9);
      nb   = $urandom_range(1, 4);
      i2c_start();
      if (kind < 2) begin
        addr = 7'h27 ^ 7'(1 << $urandom_range(0, 6));
        write_byte({addr, 1'($urandom_range(0, 1))}, 1'b0, ack);
        check("rnd_bad_nack", 32'(ack), 32'd0);
        write_byte(8'($urandom), 1'b0, ack);
        check("rnd_bad_ign", 32'(ack), 32'd0);
      end else if (kind < 4) begin
        write_byte(8'h4F, 1'b0, ack);
        check("rnd_rd_ack", 32'(ack), 32'd1);
        for (int k = 0; k < nb; k++) begin
          read_byte((k == nb - 1) ? 1'b1 : 1'b0, d);
          check("rnd_rd_data", 32'(d), 32'(m_port));
        end
      end else begin
        write_byte(8'h4E, 1'b0, ack);
        check("rnd_wr_ack", 32'(ack), 32'd1);
        for (int k = 0; k < nb; k++) begin
          wr_lcd(8'($urandom));
        end
      end
      i2c_stop();
      tick(4);
      check("rnd_busy", 32'(busy), 32'd0);
      check("rnd_port", 32'(port_out), 32'(m_port));
    end

    tick(4);
    check("port_q_drained", 32'(exp_port_q.size()), 32'd0);
    check("lcd_q_drained", 32'(exp_lcd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
